alu_cmd_issuer: RTL

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer.sv | 85 ++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands in a FIFO, issues them to an external ALU,
// waits LAT cycles for it to settle and returns the captured result.
module alu_cmd_issuer #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int LAT   = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [W-1:0] cmd_a,
   input  logic [W-1:0] cmd_b,
   input  logic [1:0]   cmd_op,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [1:0]   alu_opcode,
   input  logic [W-1:0] alu_out,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic [1:0]   rsp_op,
   output logic         busy,
   output logic [7:0]   done_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 2 * W + 2;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t          state;
   logic [EW-1:0]   mem [DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [AW:0]     count;
   logic [3:0]      settle;
   logic            push, pop;
   assign cmd_ready = count != (AW + 1)'(DEPTH);
   assign push      = cmd_valid && cmd_ready;
   assign pop       = state == IDLE && count != '0;
   assign busy      = state != IDLE || count != '0;
   // storage carries no reset; occupancy and pointers define what is valid
   always_ff @(posedge clk)
      if (push) mem[wptr] <= {cmd_a, cmd_b, cmd_op};
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         settle     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_op     <= '0;
         done_count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         if (push && !pop) count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         case (state)
            IDLE: if (pop) begin
               {alu_a, alu_b, alu_opcode} <= mem[rptr];
               settle <= 4'(LAT);
               state  <= WAIT;
            end
            WAIT: begin
               settle <= settle - 1'b1;
               if (settle == 4'd1) begin
                  rsp_data  <= alu_out;
                  rsp_op    <= alu_opcode;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: if (rsp_ready) begin
               rsp_valid  <= 1'b0;
               done_count <= done_count + 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
